// File: rtl/inv_mix_column_seq_if.sv
// Stream interface for the masked single-column InvMixColumns block.
//
// Carries the input column handshake, the output column handshake and the
// randomness feed that the block consumes while it works on a column.
//
// Signals:
//   in_valid     column on in_col is valid (producer -> block)
//   in_ready     block can accept a column
//   in_col       masked column c0..c3, byte k in in_col[k], share s in bits [s*8 +: 8]
//   random_vect  four fresh random words, one per byte lane
//   rand_en      random_vect sampled at the coming edge; source must advance
//   out_valid    out_col holds a result
//   out_ready    consumer accepts out_col
//   out_col      masked InvMixColumns(in_col)
//
// Modports: master = producer/consumer/random source side, slave = the block.
interface inv_mix_column_seq_if #(
    parameter int d = 1
);
    localparam int SW = (d + 1) * 8;
    localparam int RW = d * 8;

    logic               in_valid;
    logic               in_ready;
    logic [3:0][SW-1:0] in_col;
    logic [3:0][RW-1:0] random_vect;
    logic               rand_en;
    logic               out_valid;
    logic               out_ready;
    logic [3:0][SW-1:0] out_col;

    modport master (
        output in_valid, in_col, random_vect, out_ready,
        input  in_ready, rand_en, out_valid, out_col
    );

    modport slave (
        input  in_valid, in_col, random_vect, out_ready,
        output in_ready, rand_en, out_valid, out_col
    );
endinterface

// File: rtl/inv_mix_column_seq.sv
// Masked AES InvMixColumns on one 4-byte column (decryption datapath).
//
// Each byte is a Boolean-shared encoding of d+1 bytes; the plain value is the
// XOR of all shares. The block forms x2, x4 and x8 of every byte with three
// sequential masked doublings (each refreshed with fresh randomness), then
// combines the multiples with coefficients 14/11/13/9 and refreshes the
// result once more. One column is in flight at a time.
//
// Ports:
//   clk       clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   bus       slave side of inv_mix_column_seq_if (column in/out, randomness)
//   L         mul-by-2 matrix, row j is the bit mask producing output bit j
//   B_ext_MC  randomness expansion used by the doublings, one row per share bit
//   MC        randomness expansion used by the final refresh
module inv_mix_column_seq #(
    parameter int d = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    inv_mix_column_seq_if.slave          bus,
    input  logic [7:0][7:0]              L,
    input  logic [(d+1)*8-1:0][d*8-1:0]  B_ext_MC,
    input  logic [(d+1)*8-1:0][d*8-1:0]  MC
);
    localparam int SW = (d + 1) * 8;
    localparam int RW = d * 8;

    typedef enum logic [2:0] {IDLE, DBL1, DBL2, DBL3, COMB, DONE} fsm_state_e;

    fsm_state_e         state_q, state_d;
    logic [3:0][SW-1:0] m1_q, m1_d;
    logic [3:0][SW-1:0] m2_q, m2_d;
    logic [3:0][SW-1:0] m4_q, m4_d;
    logic [3:0][SW-1:0] m8_q, m8_d;
    logic [3:0][SW-1:0] outCol_q, outCol_d;
    logic [3:0][SW-1:0] dblSrc;
    logic [3:0][SW-1:0] dblRes;
    logic [3:0][SW-1:0] mixRes;

    // Spreads a random word over all shares; the matrix rows are chosen so the
    // contributions XOR to zero, leaving the decoded value untouched.
    function automatic logic [SW-1:0] expandRand(input logic [RW-1:0] r,
                                                 input logic [SW-1:0][RW-1:0] m);
        logic [SW-1:0] e;
        e = '0;
        for (int j = 0; j < SW; j++) begin
            e[j] = ^(m[j] & r);
        end
        return e;
    endfunction

    // Doubling is linear, so L is applied to every share independently.
    function automatic logic [SW-1:0] mulL2(input logic [SW-1:0]         x,
                                            input logic [RW-1:0]         r,
                                            input logic [7:0][7:0]       lm,
                                            input logic [SW-1:0][RW-1:0] bm);
        logic [SW-1:0] y;
        y = '0;
        for (int s = 0; s <= d; s++) begin
            for (int j = 0; j < 8; j++) begin
                y[s*8+j] = ^(lm[j] & x[s*8 +: 8]);
            end
        end
        return y ^ expandRand(r, bm);
    endfunction

    function automatic logic [SW-1:0] mulAddP(input logic [SW-1:0]         x,
                                              input logic [RW-1:0]         r,
                                              input logic [SW-1:0][RW-1:0] mm);
        return x ^ expandRand(r, mm);
    endfunction

    // One shared doubling bank; the state picks which multiple feeds it.
    always_comb begin
        dblSrc = m4_q;
        if (state_q == DBL1) begin
            dblSrc = m1_q;
        end else if (state_q == DBL2) begin
            dblSrc = m2_q;
        end
        for (int k = 0; k < 4; k++) begin
            dblRes[k] = mulL2(dblSrc[k], bus.random_vect[k], L, B_ext_MC);
        end
    end

    // 14*c_i ^ 11*c_{i+1} ^ 13*c_{i+2} ^ 9*c_{i+3}; share-wise XOR needs no refresh,
    // only the final sum is refreshed.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mixRes[i] = mulAddP(
                m8_q[i] ^ m4_q[i] ^ m2_q[i] ^
                m8_q[(i+1)%4] ^ m2_q[(i+1)%4] ^ m1_q[(i+1)%4] ^
                m8_q[(i+2)%4] ^ m4_q[(i+2)%4] ^ m1_q[(i+2)%4] ^
                m8_q[(i+3)%4] ^ m1_q[(i+3)%4],
                bus.random_vect[i], MC);
        end
    end

    always_comb begin
        state_d       = state_q;
        m1_d          = m1_q;
        m2_d          = m2_q;
        m4_d          = m4_q;
        m8_d          = m8_q;
        outCol_d      = outCol_q;
        bus.in_ready  = 1'b0;
        bus.rand_en   = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_col   = outCol_q;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    m1_d    = bus.in_col;
                    state_d = DBL1;
                end
            end
            DBL1: begin
                bus.rand_en = 1'b1;
                m2_d        = dblRes;
                state_d     = DBL2;
            end
            DBL2: begin
                bus.rand_en = 1'b1;
                m4_d        = dblRes;
                state_d     = DBL3;
            end
            DBL3: begin
                bus.rand_en = 1'b1;
                m8_d        = dblRes;
                state_d     = COMB;
            end
            COMB: begin
                bus.rand_en = 1'b1;
                outCol_d    = mixRes;
                state_d     = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            m1_q     <= '0;
            m2_q     <= '0;
            m4_q     <= '0;
            m8_q     <= '0;
            outCol_q <= '0;
        end else begin
            state_q  <= state_d;
            m1_q     <= m1_d;
            m2_q     <= m2_d;
            m4_q     <= m4_d;
            m8_q     <= m8_d;
            outCol_q <= outCol_d;
        end
    end
endmodule
